// File: rtl/e_hazard_unit_if.sv
// Signal bundle between the D/E pipeline control and the hazard unit.
// master = pipeline side, slave = hazard unit.
interface e_hazard_unit_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 2,
  parameter int CNT_W = 32
);
  logic [NSRC*5-1:0]     D_Src;
  logic [NSRC*2-1:0]     D_Tuse;
  logic                  D_IsMD;
  logic [NSRC*5-1:0]     E_Src;
  logic [NSRC*WIDTH-1:0] E_RD;
  logic                  E_GRFWE, M_GRFWE, W_GRFWE;
  logic [4:0]            E_Addr, M_Addr, W_Addr;
  logic [1:0]            E_Tnew, M_Tnew;
  logic [WIDTH-1:0]      M_WD, W_WD;
  logic                  MD_Start;
  logic                  MD_IsDiv;
  logic                  Stall;
  logic [NSRC*WIDTH-1:0] E_FwdRD;
  logic                  MD_Busy;
  logic [CNT_W-1:0]      StallCount;

  modport master (
    output D_Src, D_Tuse, D_IsMD, E_Src, E_RD,
           E_GRFWE, M_GRFWE, W_GRFWE, E_Addr, M_Addr, W_Addr,
           E_Tnew, M_Tnew, M_WD, W_WD, MD_Start, MD_IsDiv,
    input  Stall, E_FwdRD, MD_Busy, StallCount
  );

  modport slave (
    input  D_Src, D_Tuse, D_IsMD, E_Src, E_RD,
           E_GRFWE, M_GRFWE, W_GRFWE, E_Addr, M_Addr, W_Addr,
           E_Tnew, M_Tnew, M_WD, W_WD, MD_Start, MD_IsDiv,
    output Stall, E_FwdRD, MD_Busy, StallCount
  );
endinterface

// File: rtl/e_hazard_unit.sv
// Hazard/forwarding control for the 5-stage pipe: per-operand M/W forwarding,
// Tuse/Tnew stalls, MD busy tracker. Optional stall counter: HAZARD_PERF_CNT_EN.
module e_hazard_lane #(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       d_src,
  input  logic [1:0]       d_tuse,
  input  logic [4:0]       e_src,
  input  logic [WIDTH-1:0] e_rd,
  input  logic             e_grfwe,
  input  logic [4:0]       e_addr,
  input  logic [1:0]       e_tnew,
  input  logic             m_grfwe,
  input  logic [4:0]       m_addr,
  input  logic [1:0]       m_tnew,
  input  logic [WIDTH-1:0] m_wd,
  input  logic             w_grfwe,
  input  logic [4:0]       w_addr,
  input  logic [WIDTH-1:0] w_wd,
  output logic [WIDTH-1:0] fwd_rd,
  output logic             hazard
);
  logic m_hit, w_hit, e_hz, m_hz;

  // $0 is never forwarded; W results are always ready (Tnew=0)
  assign m_hit  = m_grfwe && (m_addr == e_src) && (e_src != 5'd0) && (m_tnew == 2'd0);
  assign w_hit  = w_grfwe && (w_addr == e_src) && (e_src != 5'd0);
  assign fwd_rd = m_hit ? m_wd : (w_hit ? w_wd : e_rd);

  assign e_hz   = e_grfwe && (e_addr == d_src) && (d_tuse < e_tnew);
  assign m_hz   = m_grfwe && (m_addr == d_src) && (d_tuse < m_tnew);
  assign hazard = (d_src != 5'd0) && (e_hz || m_hz);
endmodule

module e_hazard_unit #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  e_hazard_unit_if.slave bus
);
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [NSRC-1:0][WIDTH-1:0] fwd;
  logic [NSRC-1:0]            data_hz;
  logic [3:0]                 mdcnt;
  logic                       md_busy, stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    e_hazard_lane #(.WIDTH(WIDTH)) u_lane (
      .d_src   (bus.D_Src[i*5 +: 5]),
      .d_tuse  (bus.D_Tuse[i*2 +: 2]),
      .e_src   (bus.E_Src[i*5 +: 5]),
      .e_rd    (bus.E_RD[i*WIDTH +: WIDTH]),
      .e_grfwe (bus.E_GRFWE),
      .e_addr  (bus.E_Addr),
      .e_tnew  (bus.E_Tnew),
      .m_grfwe (bus.M_GRFWE),
      .m_addr  (bus.M_Addr),
      .m_tnew  (bus.M_Tnew),
      .m_wd    (bus.M_WD),
      .w_grfwe (bus.W_GRFWE),
      .w_addr  (bus.W_Addr),
      .w_wd    (bus.W_WD),
      .fwd_rd  (fwd[i]),
      .hazard  (data_hz[i])
    );
  end

  // mdcnt==0 is IDLE; a start while busy is dropped rather than reloading
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         mdcnt <= 4'd0;
    else if (bus.MD_Start && mdcnt == 4'd0) mdcnt <= bus.MD_IsDiv ? DIV_LOAD : MULT_LOAD;
    else if (mdcnt != 4'd0)               mdcnt <= mdcnt - 4'd1;
  end

  assign md_busy     = bus.MD_Start || (mdcnt != 4'd0);
  assign stall       = (|data_hz) || (bus.D_IsMD && md_busy);
  assign bus.MD_Busy = md_busy;
  assign bus.Stall   = stall;
  assign bus.E_FwdRD = fwd;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          stall_cnt <= '0;
    else if (stall && stall_cnt != '1)     stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.StallCount = stall_cnt;
`else
  assign bus.StallCount = {CNT_W{1'b0}};
`endif
endmodule
